pmem_responder: RTL

//  Physical-memory responder at the far end of the pmem_* line interface driven by the arbiter.

---
 rtl/pmem_pkg.sv | 13 +
 rtl/pmem_responder_if.sv | 22 ++
 rtl/pmem_lat_lfsr.sv | 32 +++
 rtl/pmem_responder.sv | 133 +++++++++++++
 4 files changed

// File: rtl/pmem_pkg.sv
// Shared types and constants for the pmem line responder.
package pmem_pkg;

    localparam int unsigned PMEM_LINE_BITS   = 256;
    localparam int unsigned PMEM_OFFSET_BITS = 5;

    typedef logic [31:0]               rv32i_word;
    typedef logic [PMEM_LINE_BITS-1:0] pmem_line_t;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} pmem_state_t;
    typedef enum logic       {OP_RD, OP_WR}     pmem_op_t;

endpackage

// File: rtl/pmem_responder_if.sv
// pmem_* line interface between an initiator (arbiter) and the memory responder.
interface pmem_responder_if;
    import pmem_pkg::*;

    rv32i_word  pmem_address;
    pmem_line_t pmem_wdata;
    logic       pmem_read;
    logic       pmem_write;
    pmem_line_t pmem_rdata;
    logic       pmem_resp;

    modport master (
        output pmem_address, pmem_wdata, pmem_read, pmem_write,
        input  pmem_rdata, pmem_resp
    );

    modport slave (
        input  pmem_address, pmem_wdata, pmem_read, pmem_write,
        output pmem_rdata, pmem_resp
    );

endinterface

// File: rtl/pmem_lat_lfsr.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11) producing 0..7 extra latency cycles.
module pmem_lat_lfsr (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        step_i,
    input  logic [15:0] seed_i,
    output logic [2:0]  extra_o
);

    logic [15:0] lfsr_q, lfsr_d;
    logic        fb;

    always_comb begin
        fb     = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
        lfsr_d = lfsr_q;
        if (step_i) begin
            lfsr_d = {lfsr_q[14:0], fb};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= seed_i;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    // Extra latency comes from the pre-advance value seen in the accepting cycle.
    assign extra_o = lfsr_q[2:0];

endmodule

// File: rtl/pmem_responder.sv
// Line-granular main-memory model answering pmem_* requests after a programmable latency.
// Define PMEM_RAND_LAT_EN to add 0..7 pseudo-random cycles of latency per request.
module pmem_responder
    import pmem_pkg::*;
#(
    parameter int unsigned DEPTH     = 1024,
    parameter int unsigned LATENCY   = 4,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    pmem_responder_if.slave         pmem_io,
    output logic                    busy_o,
    output logic                    proto_err_o
);

    localparam int unsigned IdxW = $clog2(DEPTH);
    localparam int unsigned CntW = $clog2(LATENCY + 8) + 1;

    pmem_state_t         state_q, state_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [IdxW-1:0]     idx_q, idx_d;
    pmem_line_t          wdata_q, wdata_d;
    pmem_op_t            op_q, op_d;
    pmem_line_t          rdata_q;
    logic                proto_err_q, proto_err_d;
    logic                commit;

    pmem_line_t          mem [DEPTH];

    logic                req;
    logic                accept;
    logic [2:0]          extra;
    logic [CntW-1:0]     total;

    assign req    = pmem_io.pmem_read | pmem_io.pmem_write;
    assign accept = (state_q == IDLE) && req;

`ifdef PMEM_RAND_LAT_EN
    pmem_lat_lfsr u_lat_lfsr (
        .clk     (clk),
        .rst_n   (rst_n),
        .step_i  (accept),
        .seed_i  (LFSR_SEED),
        .extra_o (extra)
    );
`else
    logic [15:0] unused_lfsr_seed;
    assign unused_lfsr_seed = LFSR_SEED;
    assign extra            = 3'd0;
`endif

    assign total = CntW'(LATENCY) + CntW'(extra);

    // commit marks the edge entering RESP; the array and rdata act on the *_d values so a
    // latency-1 request is served straight from the inputs.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        wdata_d     = wdata_q;
        op_d        = op_q;
        proto_err_d = proto_err_q;
        commit      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    idx_d   = pmem_io.pmem_address[PMEM_OFFSET_BITS +: IdxW];
                    wdata_d = pmem_io.pmem_wdata;
                    op_d    = pmem_io.pmem_write ? OP_WR : OP_RD;
                    if (pmem_io.pmem_read && pmem_io.pmem_write) begin
                        proto_err_d = 1'b1;
                    end
                    if (total == CntW'(1)) begin
                        state_d = RESP;
                        commit  = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = total - CntW'(2);
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                    commit  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            wdata_q     <= '0;
            op_q        <= OP_RD;
            proto_err_q <= 1'b0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            wdata_q     <= wdata_d;
            op_q        <= op_d;
            proto_err_q <= proto_err_d;
            if (commit && (op_d == OP_RD)) begin
                rdata_q <= mem[idx_d];
            end
        end
    end

    // Array is not reset; a reset during WAIT leaves commit low, so no write lands.
    always_ff @(posedge clk) begin
        if (commit && (op_d == OP_WR)) begin
            mem[idx_d] <= wdata_d;
        end
    end

    assign pmem_io.pmem_resp  = (state_q == RESP);
    assign pmem_io.pmem_rdata = rdata_q;
    assign busy_o             = (state_q != IDLE);
    assign proto_err_o        = proto_err_q;

    logic unused_addr;
    assign unused_addr = ^pmem_io.pmem_address;

endmodule
